gpio_irq_sequencer: RTL and testbench
=====================================

Name: gpio_irq_sequencer

Overview:
- Avalon-MM master that configures one prog_gpio instance and services its interrupt autonomously.
- On `start` it programs polarity, enable and mask, then clears any stale interrupt.
- It then waits for `irq`, reads the input data register and pushes the value as an event on a valid/ready stream.
- It acknowledges the interrupt only after the consumer accepts the event, so events are never lost.
- Sits between the GPIO slave and a downstream event consumer (CPU-side FIFO or logger).

Parameters:
- `DW`, 32, GPIO data width (matches the GPIO registers).
- `CNT_W`, 16, width of the event counter.
- `HOLD_CYC`, 2, cycles waited after the ack write before `irq` is sampled again (covers the GPIO's registered ack plus its registered irq).

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous active-low reset
- `start`  in  1  pulse: (re)configure and arm
- `stop`  in  1  pulse: disarm and return to idle
- `cfg_enable`  in  DW  value written to GPIO enable (addr 4)
- `cfg_mask`  in  DW  value written to GPIO irq mask (addr 8)
- `cfg_pol`  in  DW  value written to GPIO irq polarity (addr 12)
- `avm_write`  out  1  write strobe to GPIO
- `avm_address`  out  5  GPIO register address
- `avm_writedata`  out  DW  GPIO write data
- `avm_readdata`  in  DW  GPIO read data; combinational from address, zero wait state
- `irq`  in  1  GPIO interrupt
- `evt_valid`  out  1  event available
- `evt_data`  out  DW  captured GPIO input (`data_in & enable`)
- `evt_ready`  in  1  consumer accepts event
- `busy`  out  1  FSM not in IDLE
- `evt_count`  out  CNT_W  number of accepted events; wraps

Behaviour:
- Clock and reset: single clock `clk`; `reset_n` asynchronous, active-low.
- Reset values: all outputs 0; FSM = IDLE.
- All master outputs are registered FSM outputs; `avm_write` is high for exactly one cycle per write state.
- FSM states and transitions:
  - IDLE: `start` → POL.
  - POL: write `cfg_pol` to addr 12 → EN.
  - EN: write `cfg_enable` to addr 4 → MASK.
  - MASK: write `cfg_mask` to addr 8 → CLR.
  - CLR: write addr 16 (ack, data 0) → HOLD.
  - HOLD: count `HOLD_CYC` cycles with no bus activity → WAIT.
  - WAIT: `irq`=1 → READ.
  - READ: `avm_address`=0, `avm_write`=0; `avm_readdata` captured into `evt_data` at the end of this cycle → PUSH.
  - PUSH: `evt_valid`=1, `evt_data` stable until `evt_ready`. On valid&ready, `evt_count`++ → ACK.
  - ACK: write addr 16 → HOLD.
  - DISARM: write 0 to addr 8 → IDLE.
- Configuration values are sampled in their respective write states, not at `start`.
- Latency: `start` to first WAIT = 5 + `HOLD_CYC` cycles.
- Interrupt service: `irq` seen in WAIT gives `evt_valid` 2 cycles later.
- Level-sensitive re-trigger: if the GPIO condition persists, the GPIO re-asserts `irq` after the ack, and the FSM produces another event after HOLD. This is intended.
- `stop` handling:
  - In WAIT or HOLD → DISARM.
  - In a config or CLR state: remembered and applied on reaching HOLD.
  - In READ/PUSH: event completes (valid&ready), then ACK, then DISARM instead of HOLD.
  - In IDLE: ignored.
- `start` handling:
  - In WAIT: → POL (reconfigure). Pending `stop` is cleared.
  - Elsewhere outside IDLE: ignored.
  - `start` and `stop` in the same cycle: `stop` wins.
- `evt_valid` must never drop without `evt_ready`. `evt_ready` outside PUSH is ignored.
- `evt_count` wraps from 2^CNT_W−1 to 0.
- Asynchronous reset mid-transaction: outputs clear immediately and `avm_write` deasserts. The GPIO is not reconfigured until the next `start`.
- `busy` = 1 in every state except IDLE.

Optional Feature:
- Macro: `GPIO_SEQ_TIMESTAMP_EN`.
- Defined:
  - Adds output `evt_time` [31:0] and a free-running 32-bit cycle counter (reset 0, wraps).
  - `evt_time` latches the counter in the WAIT cycle where `irq` is seen.
  - It is held with `evt_data` for the whole PUSH.
- Undefined: no counter, no `evt_time` port; behaviour otherwise identical.

Test Plan:
- Config sequence: reset, `start` with `cfg_pol`=0x0, `cfg_enable`=0xFF, `cfg_mask`=0x0F → writes in consecutive cycles: (12, 0x0), (4, 0xFF), (8, 0x0F), (16, 0x0); `busy`=1; WAIT reached 7 cycles after `start`.
- Single event: in WAIT drive `irq`=1 with `avm_readdata`=0x05 at addr 0, `evt_ready`=1 → `evt_valid` 2 cycles later with `evt_data`=0x05; `evt_count`=1; addr-16 write follows, then 2 idle cycles.
- Backpressure: `evt_ready`=0 for 10 cycles in PUSH → `evt_valid` and `evt_data` stable, no ack write until the `evt_ready`=1 cycle; `evt_count` increments exactly once.
- `stop` in PUSH: `stop` pulse while `evt_ready`=0, then `evt_ready`=1 → writes (16, 0) then (8, 0); IDLE; `busy`=0; a subsequent `irq` is ignored.
- Reset mid-config: deassert `reset_n` during the EN write → `avm_write`=0 immediately, `evt_count`=0, IDLE; after release, a fresh `start` repeats the full 4-write sequence.
- Timestamp (`GPIO_SEQ_TIMESTAMP_EN`): `irq` seen at cycle 100 after reset release → `evt_time`=100 throughout PUSH; without the macro, the port is absent and the design compiles.

Source files
------------

// File: rtl/gpio_irq_sequencer.sv
// rtl/gpio_irq_sequencer.sv - Avalon-MM master that configures a prog_gpio and services its interrupt
// Optional feature macro: GPIO_SEQ_TIMESTAMP_EN (adds evt_time and a free-running cycle counter)
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   start, stop                   pulses: (re)configure and arm / disarm
//   cfg_enable, cfg_mask, cfg_pol values written to GPIO enable (4), mask (8), polarity (12)
//   avm_write, avm_address,
//   avm_writedata, avm_readdata   Avalon-MM master port to the GPIO (zero wait state reads)
//   irq                           GPIO interrupt
//   evt_valid, evt_data, evt_ready event stream carrying captured GPIO input values
//   busy                          sequencer not idle
//   evt_time                      cycle count when irq was seen (macro builds only)
//   evt_count                     number of accepted events, wrapping
module gpio_irq_sequencer #(
    parameter int DW       = 32,
    parameter int CNT_W    = 16,
    parameter int HOLD_CYC = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic [DW-1:0]    cfg_enable,
    input  logic [DW-1:0]    cfg_mask,
    input  logic [DW-1:0]    cfg_pol,
    output logic             avm_write,
    output logic [4:0]       avm_address,
    output logic [DW-1:0]    avm_writedata,
    input  logic [DW-1:0]    avm_readdata,
    input  logic             irq,
    output logic             evt_valid,
    output logic [DW-1:0]    evt_data,
    input  logic             evt_ready,
    output logic             busy,
`ifdef GPIO_SEQ_TIMESTAMP_EN
    output logic [31:0]      evt_time,
`endif
    output logic [CNT_W-1:0] evt_count
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_POL    = 4'd1;
    localparam logic [3:0] S_EN     = 4'd2;
    localparam logic [3:0] S_MASK   = 4'd3;
    localparam logic [3:0] S_CLR    = 4'd4;
    localparam logic [3:0] S_HOLD   = 4'd5;
    localparam logic [3:0] S_WAIT   = 4'd6;
    localparam logic [3:0] S_READ   = 4'd7;
    localparam logic [3:0] S_PUSH   = 4'd8;
    localparam logic [3:0] S_ACK    = 4'd9;
    localparam logic [3:0] S_DISARM = 4'd10;

    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    logic [3:0]    state;
    logic [3:0]    state_nx;
    logic [HW-1:0] hold_cnt;
    logic          hold_done;
    logic          stop_pend;

    assign hold_done = (hold_cnt == HW'(HOLD_CYC - 1));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start && !stop) state_nx = S_POL;
            S_POL:    state_nx = S_EN;
            S_EN:     state_nx = S_MASK;
            S_MASK:   state_nx = S_CLR;
            S_CLR:    state_nx = S_HOLD;
            S_HOLD: begin
                if (stop || stop_pend) state_nx = S_DISARM;
                else if (hold_done)    state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (stop)       state_nx = S_DISARM;
                else if (start) state_nx = S_POL;
                else if (irq)   state_nx = S_READ;
            end
            S_READ:   state_nx = S_PUSH;
            // evt_valid is high for the whole of PUSH, so ready alone completes the handshake
            S_PUSH:   if (evt_ready) state_nx = S_ACK;
            S_ACK:    state_nx = (stop || stop_pend) ? S_DISARM : S_HOLD;
            S_DISARM: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // A stop that arrives while the sequencer cannot leave immediately is parked here
    // and honoured at the next HOLD/ACK decision point; a reconfigure discards it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stop_pend <= 1'b0;
        end else if (state_nx == S_IDLE || state_nx == S_POL) begin
            stop_pend <= 1'b0;
        end else if (stop && state != S_IDLE) begin
            stop_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= '0;
        end else if (state == S_HOLD) begin
            hold_cnt <= hold_cnt + HW'(1);
        end else begin
            hold_cnt <= '0;
        end
    end

    // Bus and stream outputs are registered from the next state so they line up
    // exactly with the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            evt_valid     <= 1'b0;
            evt_data      <= '0;
            evt_count     <= '0;
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
        end else begin
            state         <= state_nx;
            busy          <= (state_nx != S_IDLE);
            evt_valid     <= (state_nx == S_PUSH);
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
            case (state_nx)
                S_POL: begin
                    avm_write     <= 1'b1;
                    avm_address   <= 5'd12;
                    avm_writedata <= cfg_pol;
                end
                S_EN: begin
                    avm_write     <= 1'b1;
                    avm_address   <= 5'd4;
                    avm_writedata <= cfg_enable;
                end
                S_MASK: begin
                    avm_write     <= 1'b1;
                    avm_address   <= 5'd8;
                    avm_writedata <= cfg_mask;
                end
                S_CLR, S_ACK: begin
                    avm_write     <= 1'b1;
                    avm_address   <= 5'd16;
                end
                S_DISARM: begin
                    avm_write     <= 1'b1;
                    avm_address   <= 5'd8;
                end
                default: ;
            endcase
            // Address 0 is presented during READ, so readdata is the GPIO input register
            if (state == S_READ) begin
                evt_data <= avm_readdata;
            end
            if (state == S_PUSH && evt_ready) begin
                evt_count <= evt_count + CNT_W'(1);
            end
        end
    end

`ifdef GPIO_SEQ_TIMESTAMP_EN
    logic [31:0] cyc_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_cnt  <= '0;
            evt_time <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (state == S_WAIT && state_nx == S_READ) begin
                evt_time <= cyc_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gpio_irq_sequencer.sv
// tb/tb_gpio_irq_sequencer.sv - randomized self-checking bench for gpio_irq_sequencer
module tb_gpio_irq_sequencer;

    localparam int DW       = 32;
    localparam int CNT_W    = 4;
    localparam int HOLD_CYC = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic             stop;
    logic [DW-1:0]    cfg_enable;
    logic [DW-1:0]    cfg_mask;
    logic [DW-1:0]    cfg_pol;
    logic             avm_write;
    logic [4:0]       avm_address;
    logic [DW-1:0]    avm_writedata;
    logic [DW-1:0]    avm_readdata;
    logic             irq;
    logic             evt_valid;
    logic [DW-1:0]    evt_data;
    logic             evt_ready;
    logic             busy;
    logic [CNT_W-1:0] evt_count;
    logic [DW-1:0]    gpio_in;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_events = 0;

    always #5 clk = ~clk;

    // Zero-wait GPIO register file: only the input data register is modelled
    assign avm_readdata = (avm_address == 5'd0) ? gpio_in : 32'hDEAD_BEEF;

`ifdef GPIO_SEQ_TIMESTAMP_EN
    logic [31:0] evt_time;
    int unsigned cycles_since_reset;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cycles_since_reset <= 0;
        else          cycles_since_reset <= cycles_since_reset + 1;
    end
`endif

    gpio_irq_sequencer #(
        .DW       (DW),
        .CNT_W    (CNT_W),
        .HOLD_CYC (HOLD_CYC)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .stop          (stop),
        .cfg_enable    (cfg_enable),
        .cfg_mask      (cfg_mask),
        .cfg_pol       (cfg_pol),
        .avm_write     (avm_write),
        .avm_address   (avm_address),
        .avm_writedata (avm_writedata),
        .avm_readdata  (avm_readdata),
        .irq           (irq),
        .evt_valid     (evt_valid),
        .evt_data      (evt_data),
        .evt_ready     (evt_ready),
        .busy          (busy),
`ifdef GPIO_SEQ_TIMESTAMP_EN
        .evt_time      (evt_time),
`endif
        .evt_count     (evt_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_bus(input string tag, input logic w, input logic [4:0] a, input logic [DW-1:0] d);
        check({tag, ".write"}, avm_write, w);
        if (w) begin
            check({tag, ".addr"}, avm_address, a);
            check({tag, ".data"}, avm_writedata, d);
        end
    endtask

    task automatic expect_count(input string tag);
        check(tag, evt_count, exp_events % (1 << CNT_W));
    endtask

    // Issue start (from IDLE or WAIT) and follow the four config writes and HOLD.
    // Ends in the first WAIT cycle, or in IDLE when a stop is injected mid-config.
    task automatic do_config(input logic [DW-1:0] pol, input logic [DW-1:0] en, input logic [DW-1:0] mask,
                             input bit stop_mid, input bit early_irq);
        cfg_pol = pol; cfg_enable = en; cfg_mask = mask;
        irq = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        expect_bus("cfg_pol", 1'b1, 5'd12, pol);
        check("cfg_busy", busy, 1'b1);
        if (stop_mid) stop = 1'b1;
        step();
        stop = 1'b0;
        expect_bus("cfg_en", 1'b1, 5'd4, en);
        step();
        expect_bus("cfg_mask", 1'b1, 5'd8, mask);
        step();
        expect_bus("cfg_clr", 1'b1, 5'd16, '0);
        step();
        expect_bus("cfg_hold1", 1'b0, '0, '0);
        check("cfg_hold1_busy", busy, 1'b1);
        if (stop_mid) begin
            step();
            expect_bus("cfg_disarm", 1'b1, 5'd8, '0);
            step();
            expect_bus("cfg_idle", 1'b0, '0, '0);
            check("cfg_idle_busy", busy, 1'b0);
            return;
        end
        // An irq already present during HOLD must not be serviced before WAIT
        irq = early_irq;
        step();
        expect_bus("cfg_hold2", 1'b0, '0, '0);
        check("cfg_hold2_valid", evt_valid, 1'b0);
        step();
        expect_bus("cfg_wait", 1'b0, '0, '0);
        check("cfg_wait_busy", busy, 1'b1);
    endtask

    // Starting in WAIT: idle for wait_cyc cycles, raise irq, hold off ready for
    // delay cycles, then accept. Ends in WAIT, or in IDLE when stop_push is set.
    task automatic do_event(input logic [DW-1:0] data, input int delay, input bit stop_push,
                            input int wait_cyc, input bit retrig);
`ifdef GPIO_SEQ_TIMESTAMP_EN
        int unsigned t_irq;
`endif
        for (int i = 0; i < wait_cyc; i++) begin
            irq = 1'b0;
            evt_ready = 1'($urandom_range(0, 1));
            step();
            expect_bus("wait_idle", 1'b0, '0, '0);
            check("wait_valid", evt_valid, 1'b0);
        end
        gpio_in = data;
        irq = 1'b1;
        evt_ready = 1'($urandom_range(0, 1));
`ifdef GPIO_SEQ_TIMESTAMP_EN
        t_irq = cycles_since_reset;
`endif
        step();
        evt_ready = 1'b0;
        check("read_valid", evt_valid, 1'b0);
        check("read_addr", avm_address, 5'd0);
        check("read_write", avm_write, 1'b0);
        step();
        gpio_in = $urandom;
        check("push_valid", evt_valid, 1'b1);
        check("push_data", evt_data, data);
        check("push_write", avm_write, 1'b0);
`ifdef GPIO_SEQ_TIMESTAMP_EN
        check("push_time", evt_time, t_irq);
`endif
        for (int d = 0; d < delay; d++) begin
            if (stop_push && d == 0) stop = 1'b1;
            step();
            stop = 1'b0;
            check("bp_valid", evt_valid, 1'b1);
            check("bp_data", evt_data, data);
            check("bp_write", avm_write, 1'b0);
            expect_count("bp_count");
`ifdef GPIO_SEQ_TIMESTAMP_EN
            check("bp_time", evt_time, t_irq);
`endif
        end
        evt_ready = 1'b1;
        step();
        exp_events++;
        evt_ready = 1'b0;
        irq = retrig;
        expect_bus("ack", 1'b1, 5'd16, '0);
        check("ack_valid", evt_valid, 1'b0);
        expect_count("ack_count");
        if (stop_push) begin
            irq = 1'b0;
            step();
            expect_bus("push_disarm", 1'b1, 5'd8, '0);
            step();
            expect_bus("push_idle", 1'b0, '0, '0);
            check("push_idle_busy", busy, 1'b0);
            return;
        end
        for (int h = 0; h < HOLD_CYC; h++) begin
            step();
            expect_bus("hold", 1'b0, '0, '0);
            check("hold_valid", evt_valid, 1'b0);
        end
        step();
        expect_bus("rewait", 1'b0, '0, '0);
        check("rewait_busy", busy, 1'b1);
    endtask

    initial begin
        int r;
        reset_n = 1'b0;
        start = 1'b0; stop = 1'b0; irq = 1'b0; evt_ready = 1'b0;
        cfg_enable = '0; cfg_mask = '0; cfg_pol = '0; gpio_in = '0;
        repeat (3) step();
        check("rst_write", avm_write, 1'b0);
        check("rst_addr", avm_address, 5'd0);
        check("rst_wdata", avm_writedata, '0);
        check("rst_valid", evt_valid, 1'b0);
        check("rst_data", evt_data, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_count", evt_count, '0);
        reset_n = 1'b1;
        step();

        // Stop in IDLE is ignored; start together with stop loses
        stop = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        step();
        check("idle_stop_busy", busy, 1'b0);
        check("idle_stop_write", avm_write, 1'b0);

        // Basic config sequence and a single event
        do_config(32'h0, 32'hFF, 32'h0F, 1'b0, 1'b1);
        do_event(32'h05, 0, 1'b0, 0, 1'b0);
        // Backpressure for 10 cycles
        do_event($urandom, 10, 1'b0, 2, 1'b1);

        // Randomized mix of events, reconfigures and disarms
        for (int it = 0; it < 32; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                do_config($urandom, $urandom, $urandom, 1'b0, 1'($urandom_range(0, 1)));
            end else if (r == 1) begin
                irq = 1'b0;
                stop = 1'b1;
                start = 1'($urandom_range(0, 1));
                step();
                stop = 1'b0; start = 1'b0;
                expect_bus("wait_disarm", 1'b1, 5'd8, '0);
                step();
                check("wait_stop_busy", busy, 1'b0);
                irq = 1'b1;
                step();
                check("idle_irq_valid", evt_valid, 1'b0);
                do_config($urandom, $urandom, $urandom, 1'b0, 1'b0);
            end else begin
                do_event($urandom, $urandom_range(0, 4), 1'b0, $urandom_range(0, 3),
                         1'($urandom_range(0, 1)));
            end
        end

        // Stop during PUSH: event completes, ack, then disarm; later irq ignored
        do_event(32'hA5A5_0001, 3, 1'b1, 1, 1'b0);
        irq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            expect_bus("post_stop", 1'b0, '0, '0);
            check("post_stop_busy", busy, 1'b0);
            check("post_stop_valid", evt_valid, 1'b0);
        end
        irq = 1'b0;

        // Stop during config is applied on reaching HOLD
        do_config(32'h1, 32'h2, 32'h3, 1'b1, 1'b0);

        // Asynchronous reset during the EN write
        cfg_pol = 32'h11; cfg_enable = 32'h22; cfg_mask = 32'h33;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        expect_bus("pre_rst_en", 1'b1, 5'd4, 32'h22);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_write", avm_write, 1'b0);
        check("midrst_count", evt_count, '0);
        check("midrst_busy", busy, 1'b0);
        exp_events = 0;
        step();
        reset_n = 1'b1;
        step();
        check("postrst_idle", busy, 1'b0);
        do_config(32'h3, 32'hAA, 32'h55, 1'b0, 1'b0);
        do_event(32'h1234_5678, 1, 1'b0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
